// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle master-side controller for the 16-bit ALU. It accepts one
// instruction at a time, reads two operands from a small register file and
// presents them to the ALU on registered outputs. One cycle later it writes
// the ALU result back to the destination register and updates the sticky
// zero/negative flags.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   instr_*             instruction channel (valid/ready), opcode, dst,
//                       source registers A/B, carry-in
//   ld_en/ld_ready      direct register load request / acceptance
//   ld_addr, ld_data    load target register and value
//   alu_inA/inB/inC/opc registered ALU operands, carry-in and opcode
//   alu_outW/zer/neg    combinational ALU result and flags
//   done                one-cycle pulse after an instruction retires
//   flag_z, flag_n      flags of the last retired defined instruction
//   dbg_addr, dbg_data  combinational register file read port
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. instr_ready does not depend on instr_valid, and ld_ready does
// not depend on ld_en; a load has priority, so instr_ready is low whenever
// ld_en is high. Both readies are low in EXEC and while rst is high.
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int REGS  = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_opc,
  input  logic [AW-1:0]    instr_dst,
  input  logic [AW-1:0]    instr_srcA,
  input  logic [AW-1:0]    instr_srcB,
  input  logic             instr_cin,
  input  logic             ld_en,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] alu_inA,
  output logic [WIDTH-1:0] alu_inB,
  output logic             alu_inC,
  output logic [2:0]       alu_opc,
  input  logic [WIDTH-1:0] alu_outW,
  input  logic             alu_zer,
  input  logic             alu_neg,
  output logic             done,
  output logic             flag_z,
  output logic             flag_n,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] OPC_UNDEF = 3'b111;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state;
  state_t           state_nx;
  logic [AW-1:0]    dst_q;
  logic [WIDTH-1:0] regs [REGS];
  logic             accept;
  logic             load;
  logic             retire;
  logic             write_back;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, handshake outputs and per-cycle strobes.
  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    ld_ready    = 1'b0;
    accept      = 1'b0;
    load        = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE: begin
        // rst gating keeps the readies low during reset, not only after it.
        ld_ready    = !rst;
        instr_ready = !rst && !ld_en;
        load        = ld_en;
        accept      = instr_valid && !ld_en;
        if (accept) begin
          state_nx = EXEC;
        end
      end
      EXEC: begin
        retire   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The opcode register still holds the EXEC instruction, so it decides
  // whether the result is architecturally visible.
  assign write_back = retire && (alu_opc != OPC_UNDEF);

  // Operand/opcode capture at accept; values hold until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_inA <= '0;
      alu_inB <= '0;
      alu_inC <= 1'b0;
      alu_opc <= '0;
      dst_q   <= '0;
    end else if (accept) begin
      alu_inA <= regs[instr_srcA];
      alu_inB <= regs[instr_srcB];
      alu_inC <= instr_cin;
      alu_opc <= instr_opc;
      dst_q   <= instr_dst;
    end
  end

  // Register file. Loads only happen in IDLE and write-back only in EXEC,
  // so the two write sources never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (load) begin
      regs[ld_addr] <= ld_data;
    end else if (write_back) begin
      regs[dst_q] <= alu_outW;
    end
  end

  // Retire pulse and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done   <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      done <= retire;
      if (write_back) begin
        flag_z <= alu_zer;
        flag_n <= alu_neg;
      end
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer. Contains a behavioural ALU that answers
// the DUT's registered operand outputs, a reference model of the register
// file and flags, and a scoreboard checked on every done pulse.
module tb_alu_op_sequencer;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_opc;
  logic [1:0]    instr_dst;
  logic [1:0]    instr_srcA;
  logic [1:0]    instr_srcB;
  logic          instr_cin;
  logic          ld_en;
  logic          ld_ready;
  logic [1:0]    ld_addr;
  logic [W-1:0]  ld_data;
  logic [W-1:0]  alu_inA;
  logic [W-1:0]  alu_inB;
  logic          alu_inC;
  logic [2:0]    alu_opc;
  logic [W-1:0]  alu_outW;
  logic          alu_zer;
  logic          alu_neg;
  logic          done;
  logic          flag_z;
  logic          flag_n;
  logic [1:0]    dbg_addr;
  logic [W-1:0]  dbg_data;

  // dbg_addr is shared between the driver (direct reads) and the monitor.
  logic [1:0]    drv_addr;
  logic [1:0]    mon_addr;
  logic          drv_sel;
  assign dbg_addr = drv_sel ? drv_addr : mon_addr;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer #(.WIDTH(W), .REGS(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opc(instr_opc), .instr_dst(instr_dst),
    .instr_srcA(instr_srcA), .instr_srcB(instr_srcB), .instr_cin(instr_cin),
    .ld_en(ld_en), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC), .alu_opc(alu_opc),
    .alu_outW(alu_outW), .alu_zer(alu_zer), .alu_neg(alu_neg),
    .done(done), .flag_z(flag_z), .flag_n(flag_n),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: returns {neg, zer, w}. Opcode 111 yields junk so an
  // illegal write-back or flag update would be visible.
  function automatic logic [W+1:0] alu_f(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c);
    logic [W-1:0] w;
    case (op)
      3'd0: w = -a;
      3'd1: w = a - b;
      3'd2: w = a + b + {{(W-1){1'b0}}, c};
      3'd3: w = ~a;
      3'd4: w = a & b;
      3'd5: w = a | b;
      3'd6: w = a ^ b;
      default: return {1'b1, 1'b1, 16'hDEAD};
    endcase
    return {w[W-1], (w == '0), w};
  endfunction

  always_comb {alu_neg, alu_zer, alu_outW} = alu_f(alu_opc, alu_inA, alu_inB, alu_inC);

  // Reference model and scoreboard.
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   opc;
    logic         cin;
    logic [1:0]   dst;
    logic [W-1:0] res;
    logic         z;
    logic         n;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_regs [4];
  logic         m_z;
  logic         m_n;
  int           last_acc;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse retires the oldest expected instruction.
  initial begin
    exp_t e;
    mon_addr = '0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no retire (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          mon_addr = e.dst;
          #1;
          chk("latency", cyc, e.acc + 1);
          chk("opA", alu_inA, e.a);
          chk("opB", alu_inB, e.b);
          chk("opc", alu_opc, e.opc);
          chk("cin", alu_inC, e.cin);
          chk("result", dbg_data, e.res);
          chk("flag_z", flag_z, e.z);
          chk("flag_n", flag_n, e.n);
        end
      end
    end
  end

  task automatic do_load(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    if (ld_ready) m_regs[a] = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb,
                       input logic cin, input bit push);
    int n;
    logic [W+1:0] r;
    exp_t e;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_opc = op;
    instr_dst = dst;
    instr_srcA = sa;
    instr_srcB = sb;
    instr_cin = cin;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got instr_ready=0 for 20 cycles expected 1");
      instr_valid = 1'b0;
      return;
    end
    e.a = m_regs[sa];
    e.b = m_regs[sb];
    e.opc = op;
    e.cin = cin;
    e.dst = dst;
    e.acc = cyc + 1;
    last_acc = e.acc;
    if (push) begin
      r = alu_f(op, e.a, e.b, cin);
      if (op != 3'b111) begin
        m_regs[dst] = r[W-1:0];
        m_z = r[W];
        m_n = r[W+1];
      end
      e.res = m_regs[dst];
      e.z = m_z;
      e.n = m_n;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk("exec_inA", alu_inA, e.a);
    chk("exec_inB", alu_inB, e.b);
    chk("exec_ready", {instr_ready, ld_ready}, 2'b00);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [W-1:0] exp, input string name);
    wait_idle();
    drv_sel = 1'b1;
    drv_addr = a;
    #1;
    chk(name, dbg_data, exp);
    drv_sel = 1'b0;
  endtask

  initial begin
    int acc1;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_opc = '0;
    instr_dst = '0;
    instr_srcA = '0;
    instr_srcB = '0;
    instr_cin = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    drv_sel = 1'b0;
    drv_addr = '0;
    m_z = 1'b0;
    m_n = 1'b0;
    last_acc = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_outputs", {alu_inA, alu_inB, alu_inC, alu_opc, done, flag_z, flag_n,
                          instr_ready, ld_ready}, 64'd0);
    drv_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv_addr = 2'(i);
      #1;
      chk("reset_reg", dbg_data, 16'h0000);
    end
    drv_sel = 1'b0;
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {instr_ready, ld_ready}, 2'b11);

    // Add with carry.
    do_load(2'd1, 16'h0005);
    do_load(2'd2, 16'h0003);
    issue(3'b010, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1);
    rd(2'd0, 16'h0009, "add_cin_r0");
    chk("add_flags", {flag_z, flag_n}, 2'b00);

    // Negate.
    do_load(2'd1, 16'h0001);
    issue(3'b000, 2'd3, 2'd1, 2'd1, 1'b0, 1'b1);
    rd(2'd3, 16'hFFFF, "neg_r3");
    chk("neg_flags", {flag_z, flag_n}, 2'b01);

    // Zero result, then undefined opcode holds register and flags.
    do_load(2'd1, 16'h00F0);
    do_load(2'd2, 16'h0F00);
    issue(3'b100, 2'd2, 2'd1, 2'd2, 1'b0, 1'b1);
    rd(2'd2, 16'h0000, "and_r2");
    chk("and_flags", {flag_z, flag_n}, 2'b10);
    issue(3'b111, 2'd2, 2'd1, 2'd1, 1'b0, 1'b1);
    rd(2'd2, 16'h0000, "undef_r2_hold");
    chk("undef_flags_hold", {flag_z, flag_n}, 2'b10);

    // Back-to-back dependency, second accept at E2.
    do_load(2'd1, 16'h7FFF);
    do_load(2'd2, 16'h0001);
    issue(3'b010, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1);
    acc1 = last_acc;
    issue(3'b101, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1);
    chk("b2b_accept_e2", last_acc, acc1 + 2);
    rd(2'd0, 16'h8000, "dep_r0");
    rd(2'd3, 16'h8000, "dep_r3");
    chk("dep_flag_n", flag_n, 1'b1);

    // Load wins over a simultaneous instruction.
    @(negedge clk);
    ld_en = 1'b1;
    ld_addr = 2'd1;
    ld_data = 16'h1234;
    instr_valid = 1'b1;
    instr_opc = 3'b101;
    #1;
    chk("load_priority_ready", {instr_ready, ld_ready}, 2'b01);
    m_regs[1] = 16'h1234;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    instr_valid = 1'b0;
    issue(3'b101, 2'd0, 2'd1, 2'd1, 1'b0, 1'b1);
    rd(2'd0, 16'h1234, "load_then_or_r0");

    // Load during EXEC is ignored.
    issue(3'b110, 2'd3, 2'd1, 2'd2, 1'b0, 1'b1);
    @(negedge clk);
    ld_en = 1'b1;
    ld_addr = 2'd2;
    ld_data = 16'hABCD;
    #1;
    chk("exec_ld_ready", ld_ready, 1'b0);
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    rd(2'd2, 16'h0001, "exec_load_ignored");

    // Reset during EXEC aborts the instruction.
    do_load(2'd1, 16'h0011);
    do_load(2'd2, 16'h0022);
    issue(3'b010, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {alu_inA, alu_inB, alu_inC, alu_opc, done, flag_z, flag_n,
                                instr_ready, ld_ready}, 64'd0);
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_z = 1'b0;
    m_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_abort", instr_ready, 1'b1);
    rd(2'd0, 16'h0000, "abort_r0");

    // Randomized mix of loads and instructions.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load(2'($urandom_range(0, 3)), 16'($urandom));
      end else begin
        issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b1);
      end
    end
    for (int i = 0; i < 4; i++) rd(2'(i), m_regs[i], "final_reg");
    chk("final_flags", {flag_z, flag_n}, {m_z, m_n});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that drives the 16-bit ALU from the master side.
- Accepts instructions over a valid/ready handshake and reads two source operands from an internal register file.
- Drives the ALU operand, opcode and carry-in inputs, then captures outW/zer/neg.
- Writes the result back to a destination register and updates sticky flag outputs. It sits between the instruction source and the ALU in the q2 datapath.

Parameters:
WIDTH, 16, datapath and register width (must match ALU)
REGS, 4, number of general registers
AW, 2, register address width (log2 REGS)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction present
instr_ready  output  1  sequencer can accept an instruction
instr_opc  input  3  ALU opcode
instr_dst  input  AW  destination register
instr_srcA  input  AW  source register for inA
instr_srcB  input  AW  source register for inB
instr_cin  input  1  carry-in for opcode 010
ld_en  input  1  direct register load request
ld_ready  output  1  load accepted this cycle if ld_en is high
ld_addr  input  AW  load target register
ld_data  input  WIDTH  load value
alu_inA  output  WIDTH  ALU operand A (registered)
alu_inB  output  WIDTH  ALU operand B (registered)
alu_inC  output  1  ALU carry-in (registered)
alu_opc  output  3  ALU opcode (registered)
alu_outW  input  WIDTH  ALU result (combinational from the ALU)
alu_zer  input  1  ALU zero flag
alu_neg  input  1  ALU negative flag
done  output  1  one-cycle pulse: instruction retired
flag_z  output  1  last retired zero flag
flag_n  output  1  last retired negative flag
dbg_addr  input  AW  debug read address
dbg_data  output  WIDTH  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - All registers, alu_inA, alu_inB, alu_inC, alu_opc, done, flag_z and flag_n are forced to 0.
  - instr_ready=0 and ld_ready=0 while rst=1.
- States: IDLE, EXEC.
- IDLE outputs:
  - ld_ready=1.
  - instr_ready = !ld_en. A load has priority over an instruction.
- Load in IDLE: with ld_en=1, regfile[ld_addr] <= ld_data at the edge. The state stays IDLE.
- Instruction accept (edge E0, IDLE with instr_valid && instr_ready):
  - alu_inA <= reg[srcA]; alu_inB <= reg[srcB].
  - alu_opc <= instr_opc; alu_inC <= instr_cin.
  - dst is latched internally. state <= EXEC.
- EXEC, one cycle:
  - instr_ready=0 and ld_ready=0; ld_en is ignored, with no write.
  - The ALU settles combinationally.
- Retire (edge E1, leaving EXEC):
  - If the latched opc != 111: reg[dst] <= alu_outW; flag_z <= alu_zer; flag_n <= alu_neg.
  - If opc == 111 (undefined ALU op): no register write, and the flags hold.
  - In both cases done <= 1 for exactly the cycle after E1, and state <= IDLE.
- Latency and throughput:
  - Accept-to-done is 2 edges.
  - The next accept can occur at E2, so throughput is one instruction per 2 cycles.
- Hazards: the write-back at E1 precedes any later operand read (E2 or later), so a dependent instruction always sees the new value. No forwarding is needed.
- srcA == srcB is legal (same value on both operands). dst may equal either source.
- alu_* outputs hold their last value in IDLE.
- A reset asserted during EXEC aborts the instruction: no write-back and no done.
- dbg_data is purely combinational and reflects a write one cycle after the write edge.

Test Plan:
- Add with carry: load r1=0x0005 and r2=0x0003, then issue opc=010, srcA=1, srcB=2, dst=0, cin=1. Required: alu_inA=0x0005 and alu_inB=0x0003 during EXEC; r0=0x0009; flag_z=0, flag_n=0; done high exactly 1 cycle, 2 edges after accept.
- Negate: r1=0x0001, opc=000, dst=3 -> r3=0xFFFF, flag_n=1, flag_z=0.
- Zero/flags hold: r1=0x00F0, r2=0x0F00, opc=100, dst=2 -> r2=0x0000, flag_z=1. Follow with opc=111, dst=2 -> r2 stays 0x0000, flag_z stays 1, done still pulses.
- Back-to-back dependency: r0=r1+r2 (opc=010, cin=0, r1=0x7FFF, r2=0x0001), then r3 = r0 | r0 (opc=101) accepted at E2 -> r0=0x8000, then r3=0x8000, flag_n=1.
- Load contention:
  - ld_en=1 with instr_valid=1 in IDLE: the load is taken and instr_ready=0.
  - ld_en=1 during EXEC: ld_ready=0 and the target register is unchanged.
- Reset mid-op: assert rst during EXEC of r0=r1+r2 -> r0=0, done never pulses, and all outputs are 0 immediately (asynchronously). After rst falls, instr_ready=1.
